// File: rtl/ipsl_ddrphy_pkg.sv
// Shared constants for the DDR PHY reset-request scheduler.
// Parameter defaults, the guard minimum and the FSM state encodings.
package ipsl_ddrphy_pkg;

    localparam int unsigned NUM_REQ_DEF     = 3;
    localparam int unsigned TIMEOUT_CYC_DEF = 64;
    localparam int unsigned MAX_RETRY_DEF   = 2;
    localparam int unsigned GUARD_CYC_DEF   = 8;
    localparam int unsigned CNT_W_DEF       = 8;

    localparam int unsigned GUARD_CYC_MIN   = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_WAIT_ACK = 2'd1;
    localparam state_t ST_GUARD    = 2'd2;

endpackage

// File: rtl/ipsl_rr_arbiter.sv
// Combinational round-robin pick: lowest set request at or above rr_ptr_i, wrapping.
module ipsl_rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vld_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_req_o
);

    int unsigned      idx;
    logic [IDX_W-1:0] idx_w;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx   = (32'(rr_ptr_i) + k) % NUM_REQ;
            idx_w = IDX_W'(idx);
            if (!found && req_vld_i[idx_w]) begin
                grant_o = idx_w;
                found   = 1'b1;
            end
        end
    end

    assign any_req_o = |req_vld_i;

endmodule

// File: rtl/ipsl_ddrphy_rst_req_sched.sv
// Round-robin scheduler sharing the PHY DQS-reset/training request line between
// several requesters, with ack timeout, bounded retries and a low guard gap.
module ipsl_ddrphy_rst_req_sched
    import ipsl_ddrphy_pkg::*;
#(
    parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned MAX_RETRY   = MAX_RETRY_DEF,
    parameter int unsigned GUARD_CYC   = GUARD_CYC_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_vld,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    input  logic                       ddrphy_in_rst,
    output logic                       ddrphy_rst_req,
    input  logic                       ddrphy_rst_ack
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

    if (GUARD_CYC < GUARD_CYC_MIN) begin : g_guard_chk
        $error("GUARD_CYC must be at least %0d", GUARD_CYC_MIN);
    end
    if ((1 << CNT_W) <= TIMEOUT_CYC || (1 << CNT_W) <= GUARD_CYC) begin : g_cnt_chk
        $error("CNT_W too narrow for TIMEOUT_CYC/GUARD_CYC");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [RTY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic               retry_pend_q, retry_pend_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               req_q, req_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;

    logic [IDX_W-1:0]   arb_grant;
    logic               any_req;
    logic [IDX_W-1:0]   ptr_next;

    ipsl_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_vld_i (req_vld),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (arb_grant),
        .any_req_o (any_req)
    );

    assign ptr_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        retry_cnt_d  = retry_cnt_q;
        retry_pend_d = retry_pend_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        req_d        = req_q;
        done_d       = '0;
        err_d        = '0;
        case (state_q)
            ST_IDLE: begin
                if (!ddrphy_in_rst && any_req) begin
                    grant_d      = arb_grant;
                    req_d        = 1'b1;
                    timer_d      = '0;
                    retry_cnt_d  = RTY_W'(1);
                    retry_pend_d = 1'b0;
                    state_d      = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // Ack is honoured even on the timeout cycle and while the PHY is in reset.
                if (ddrphy_rst_ack) begin
                    req_d           = 1'b0;
                    done_d[grant_q] = 1'b1;
                    rr_ptr_d        = ptr_next;
                    timer_d         = '0;
                    state_d         = ST_GUARD;
                end else if (!ddrphy_in_rst) begin
                    if (timer_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        req_d   = 1'b0;
                        timer_d = '0;
                        state_d = ST_GUARD;
                        if (retry_cnt_q == RTY_W'(MAX_RETRY)) begin
                            err_d[grant_q] = 1'b1;
                            rr_ptr_d       = ptr_next;
                        end else begin
                            retry_pend_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ST_GUARD: begin
                if (!ddrphy_in_rst) begin
                    if (timer_q == CNT_W'(GUARD_CYC - 1)) begin
                        timer_d = '0;
                        if (retry_pend_q) begin
                            retry_cnt_d  = retry_cnt_q + 1'b1;
                            retry_pend_d = 1'b0;
                            req_d        = 1'b1;
                            state_d      = ST_WAIT_ACK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            retry_cnt_q  <= '0;
            retry_pend_q <= 1'b0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            req_q        <= 1'b0;
            done_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_cnt_q  <= retry_cnt_d;
            retry_pend_q <= retry_pend_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            req_q        <= req_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign req_done       = done_q;
    assign req_err        = err_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != ST_IDLE);
    assign ddrphy_rst_req = req_q;

endmodule
